lut_persist_gate: RTL
=====================

// Module: lut_persist_gate
// PURPOSE
// - Programmable N-input truth-table gate: the fixed-function 3-input gates generalised to N inputs, with a runtime-loadable table.
// - Inputs registered; table lookup registered; output passes a persistence filter and changes only after the new value holds HOLD_CYC cycles.
// - Sits between sensor-input registers and reporter outputs; one instance per logic gate in the mapped circuit netlist.
// PARAMETERS
// - N_IN      3   number of inputs (1..6); table width TT_W = 2**N_IN
// - HOLD_CYC  4   consecutive cycles a differing lookup result must persist before out flips; 0 = filter bypassed
// - CNT_W     $clog2(HOLD_CYC+1)  derived, not overridable
// PORTS
// - clk        in   1       rising-edge clock
// - rst_n      in   1       synchronous reset, active-low
// - in_vec     in   N_IN    gate inputs; in_vec[N_IN-1] = in1 (MSB of row index), in_vec[0] = inN
// - cfg_valid  in   1       table-load request
// - cfg_ready  out  1       table-load accept; transfer occurs when cfg_valid & cfg_ready at a rising edge
// - cfg_table  in   TT_W    truth table; bit cfg_table[TT_W-1-idx] = output for row idx = in_vec (MSB = all-zeros row, hex-name order)
// - out        out  1       filtered gate output
// - out_valid  out  1       out reflects the committed table for the current settled input
// - busy       out  1       filter in SETTLING
// BEHAVIOUR
// - Reset (rst_n=0 at edge): table=0, in_q=0, cand_q=0, cnt=0, state=UNCFG; out=0, out_valid=0, busy=0, cfg_ready=1. Reset wins over all other events.
// - Pipeline: edge e captures in_q<=in_vec; edge e+1 captures cand_q<=table[TT_W-1-in_q].
// - States: UNCFG, STABLE, SETTLING.
// - UNCFG: out held 0, out_valid=0, cand_q ignored; first cfg handshake -> table commits at that edge, state->STABLE, fresh=1.
// - STABLE: if cand_q!=out and fresh=0 -> SETTLING, cnt<=1; if HOLD_CYC=1 flip immediately instead (stay STABLE).
// - fresh: set on table commit; cleared at the next edge (cand_q now derived from new table). While fresh=1 the filter ignores cand_q.
// - At the edge clearing fresh: if cand_q(new)==out -> out_valid<=1; else out_valid stays 0 and normal settling applies.
// - SETTLING: each edge with cand_q!=out -> cnt++; when cnt reaches HOLD_CYC -> out<=cand_q, cnt<=0, state->STABLE, out_valid<=1.
// - SETTLING: any edge with cand_q==out -> cnt<=0, state->STABLE, out unchanged (glitch rejected).
// - HOLD_CYC=0: out<=cand_q directly each edge once configured; SETTLING never entered; busy always 0.
// - Latency: in_vec change before edge e with steady new value -> out updates at edge e+1+HOLD_CYC (HOLD_CYC+2 edges inclusive).
// - cfg_ready = 0 in SETTLING, 1 in UNCFG and STABLE. Table never changes mid-transition.
// - Table commit in STABLE: table<=cfg_table, out_valid<=0, fresh<=1, out unchanged; in-flight in_q unaffected.
// - cfg_valid held while cfg_ready=0: no transfer; accepted at first edge cfg_ready=1.
// - Reloading an identical table is a legal commit (out_valid drops for one edge, then reasserts).
// - busy = (state==SETTLING), combinational from state register.
// - Counter width CNT_W; cnt never exceeds HOLD_CYC, no wrap.
// - Reset mid-SETTLING: filter aborts, table lost, state UNCFG.
// STRUCTURE
// - Package cello_lut_pkg: typedef enum logic [1:0] {UNCFG, STABLE, SETTLING} lut_state_e;
//   function automatic tt_row(table, idx) returning table[TT_W-1-idx]; shared with gate-mapping scoreboard.
// - One sub-module: persist_filter (cand, enable, fresh -> out, out_valid, busy; parameter HOLD_CYC).
// - Top holds input register, table register, cfg handshake and lookup stage.
// TESTING
// - Reset, no cfg, toggle in_vec through all rows -> out=0, out_valid=0, cfg_ready=1 throughout.
// - Load 8'hA8 (N_IN=3, HOLD_CYC=4), step rows 000..111 holding 8 cycles each -> settled out 1,0,1,0,1,0,0,0.
// - 8'hA8, in_vec 000->001 steady before edge e -> out falls exactly at edge e+5, busy high edges e+2..e+4.
// - 8'hA8, in_vec 000->001 for 2 cycles then back to 000 -> out stays 1, busy pulses, returns to STABLE, out_valid stays 1.
// - cfg_valid with 8'h01 asserted during SETTLING -> cfg_ready=0, no commit until STABLE; then commit, out_valid low one edge.
// - HOLD_CYC=0 build, 8'hA8, in_vec 010->011 -> out 1->0 two edges later; rst_n low mid-SETTLING -> out=0, UNCFG next edge.

Source files
------------

// File: rtl/cello_lut_pkg.sv
// -----------------------------------------------------------------------------
// cello_lut_pkg
// Shared definitions for the programmable truth-table gate and for anything
// that needs to evaluate a truth table the same way (e.g. a gate-mapping
// scoreboard).
//   lut_state_e : persistence filter state
//   tt_row()    : truth-table row lookup. Row 0 (all inputs low) lives in the
//                 MSB of the table, so a table reads like its hex gate name.
// -----------------------------------------------------------------------------
package cello_lut_pkg;

   // Widest supported gate: 6 inputs, 64-entry table.
   localparam int N_IN_MAX = 6;
   localparam int TT_W_MAX = 1 << N_IN_MAX;

   typedef enum logic [1:0] {
      UNCFG    = 2'd0,
      STABLE   = 2'd1,
      SETTLING = 2'd2
   } lut_state_e;

   // tbl    : table zero-extended to TT_W_MAX bits
   // tt_w   : real table width of the caller (2**N_IN)
   // idx    : row index, zero-extended to N_IN_MAX bits
   // Returns tbl[tt_w-1-idx].
   function automatic logic tt_row(input logic [TT_W_MAX-1:0] tbl,
                                   input logic [N_IN_MAX:0]   tt_w,
                                   input logic [N_IN_MAX-1:0] idx);
      logic [N_IN_MAX:0] pos;
      pos = tt_w - {1'b0, idx} - {{N_IN_MAX{1'b0}}, 1'b1};
      return tbl[pos[N_IN_MAX-1:0]];
   endfunction

endpackage

// File: rtl/lut_persist_gate_filter.sv
// -----------------------------------------------------------------------------
// persist_filter
// Output persistence filter for the truth-table gate. The registered lookup
// result (cand) only reaches the output after it has differed from the
// current output for HOLD_CYC consecutive edges; shorter excursions are
// rejected as glitches. HOLD_CYC = 0 bypasses the filter (out follows cand
// once configured).
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   synchronous reset, active-low
//   cand      in   registered lookup result
//   cand_nxt  in   lookup result being captured this edge (already from the
//                  newly committed table while fresh is high)
//   load      in   table commit happens at this edge
//   fresh     in   the edge after a commit; cand is still from the old table
//   out       out  filtered output
//   out_valid out  out reflects the committed table for the settled input
//   busy      out  filter is SETTLING
// -----------------------------------------------------------------------------
module persist_filter
   import cello_lut_pkg::*;
#(
   parameter int HOLD_CYC = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic cand,
   input  logic cand_nxt,
   input  logic load,
   input  logic fresh,
   output logic out,
   output logic out_valid,
   output logic busy
);

   localparam int CNT_W  = $clog2(HOLD_CYC + 1);
   // HOLD_CYC = 0 gives a zero-width counter; keep one bit so the register
   // still elaborates (it never leaves zero in that build).
   localparam int CNT_RW = (CNT_W < 1) ? 1 : CNT_W;
   localparam logic [CNT_RW-1:0] CNT_ONE  = CNT_RW'(1);
   // cnt holds the number of mismatching edges already seen, so the flip
   // happens on the edge where cnt would step to HOLD_CYC.
   localparam logic [CNT_RW-1:0] CNT_LAST =
      (HOLD_CYC > 1) ? CNT_RW'(HOLD_CYC - 1) : '0;

   lut_state_e        state_q, state_n;
   logic              out_q, out_n;
   logic              ov_q, ov_n;
   logic [CNT_RW-1:0] cnt_q, cnt_n;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= UNCFG;
         out_q   <= 1'b0;
         ov_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_n;
         out_q   <= out_n;
         ov_q    <= ov_n;
         cnt_q   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state_q;
      out_n   = out_q;
      ov_n    = ov_q;
      cnt_n   = cnt_q;

      if (load) begin
         // A commit only arrives in UNCFG or STABLE and takes priority over
         // any mismatch seen on the same edge: that cand came from the table
         // being replaced.
         state_n = STABLE;
         cnt_n   = '0;
         ov_n    = 1'b0;
      end else begin
         case (state_q)
            UNCFG: begin
               // Unconfigured: cand is meaningless, hold everything.
            end
            STABLE: begin
               if (fresh) begin
                  // cand still reflects the old table; judge validity on the
                  // value now being looked up from the new one.
                  ov_n = (HOLD_CYC == 0) ? 1'b1 : (cand_nxt == out_q);
               end else if (HOLD_CYC == 0) begin
                  // Bypass build: output is driven straight from cand.
               end else if (cand != out_q) begin
                  if (HOLD_CYC == 1) begin
                     out_n = cand;
                     ov_n  = 1'b1;
                  end else begin
                     state_n = SETTLING;
                     cnt_n   = CNT_ONE;
                  end
               end
            end
            SETTLING: begin
               if (cand == out_q) begin
                  // Excursion ended before it persisted long enough.
                  state_n = STABLE;
                  cnt_n   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  out_n   = cand;
                  ov_n    = 1'b1;
                  cnt_n   = '0;
                  state_n = STABLE;
               end else begin
                  cnt_n = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_n = UNCFG;
               cnt_n   = '0;
            end
         endcase
      end
   end

   assign out       = (HOLD_CYC == 0) ? (cand && (state_q == STABLE)) : out_q;
   assign out_valid = ov_q;
   assign busy      = (state_q == SETTLING);

endmodule

// File: rtl/lut_persist_gate.sv
// -----------------------------------------------------------------------------
// lut_persist_gate
// Programmable N-input truth-table gate with a persistence-filtered output.
// Inputs are registered, the table lookup is registered, and the result goes
// through persist_filter so out changes only after the new value has held for
// HOLD_CYC cycles. The table is loaded at runtime through a valid/ready
// handshake that is refused while the filter is mid-transition.
//
// Parameters
//   N_IN      number of gate inputs (1..6), table width TT_W = 2**N_IN
//   HOLD_CYC  persistence in cycles, 0 = filter bypassed
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous reset, active-low
//   in_vec     in   gate inputs, in_vec[N_IN-1] is the row-index MSB
//   cfg_valid  in   table-load request
//   cfg_ready  out  table-load accept (low while SETTLING)
//   cfg_table  in   truth table, cfg_table[TT_W-1-row] is the output for row
//   out        out  filtered gate output
//   out_valid  out  out reflects the committed table for the settled input
//   busy       out  filter is SETTLING
// -----------------------------------------------------------------------------
module lut_persist_gate
   import cello_lut_pkg::*;
#(
   parameter int N_IN     = 3,
   parameter int HOLD_CYC = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_IN-1:0]        in_vec,
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   input  logic [(1<<N_IN)-1:0]   cfg_table,
   output logic                   out,
   output logic                   out_valid,
   output logic                   busy
);

   localparam int TT_W = 1 << N_IN;

   logic [N_IN-1:0] in_p0;
   logic            cand_p1;
   logic [TT_W-1:0] tbl_q;
   logic            fresh_q;
   logic            commit;
   logic            cand_nxt;

   // The table may only change while the filter is not mid-transition.
   assign cfg_ready = ~busy;
   assign commit    = cfg_valid & cfg_ready;

   assign cand_nxt = tt_row(TT_W_MAX'(tbl_q), (N_IN_MAX+1)'(TT_W),
                            N_IN_MAX'(in_p0));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_p0   <= '0;
         cand_p1 <= 1'b0;
         tbl_q   <= '0;
         fresh_q <= 1'b0;
      end else begin
         // Stage p0: input capture
         in_p0   <= in_vec;
         // Stage p1: table lookup on the captured inputs
         cand_p1 <= cand_nxt;
         fresh_q <= commit;
         if (commit) begin
            tbl_q <= cfg_table;
         end
      end
   end

   // Stage p2: persistence filter
   persist_filter #(
      .HOLD_CYC (HOLD_CYC)
   ) u_filter (
      .clk       (clk),
      .rst_n     (rst_n),
      .cand      (cand_p1),
      .cand_nxt  (cand_nxt),
      .load      (commit),
      .fresh     (fresh_q),
      .out       (out),
      .out_valid (out_valid),
      .busy      (busy)
   );

endmodule
